uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the team's UART receiver in the same SPART/UART block.
- Accepts a byte from the bus side into a one-entry holding register.
- Serialises the byte on TxD as start bit, DATA_BITS data bits LSB first, then stop bit.
- Single clock domain. Bit timing is paced by a baud enable pulse from the shared baud rate generator; baud_tick is never used as a clock.

---
 rtl/uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 UART transmitter with a one-entry holding register, giving
//             single-byte double buffering in front of the shift register.
//             A frame is one start bit (0), DATA_BITS data bits sent LSB
//             first, then one stop bit (1). Each bit lasts OVERSAMPLE baud
//             ticks. baud_tick is a clock enable, never a clock.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          system clock
//    reset      in   1          synchronous active-high reset
//    baud_tick  in   1          one-clk enable at OVERSAMPLE x baud rate
//    tx_data    in   DATA_BITS  byte to transmit
//    tx_load    in   1          write strobe, accepted only while TBR=1
//    TxD        out  1          serial line, idle high, registered
//    TBR        out  1          1 = holding register empty
//    tx_busy    out  1          1 while a frame (start..stop) is on the line
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 TxD,
    output logic                 TBR,
    output logic                 tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [3:0] c_TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_BIT_LAST  = 3'(DATA_BITS - 1);

    // Registered state
    state_t                 r_state;
    logic [3:0]             r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_full;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_txd;
    logic                   r_busy;

    // Next-state values
    state_t                 w_state_nxt;
    logic [3:0]             w_tick_nxt;
    logic [2:0]             w_bit_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_txd_nxt;
    logic                   w_busy_nxt;
    logic                   w_transfer;
    logic                   w_load_ok;
    logic                   w_last_tick;

    // A load is only taken into an empty holding register; a load attempted
    // while full is silently dropped. The transfer requires a full register,
    // so load and transfer can never happen on the same cycle.
    assign w_load_ok   = tx_load & ~r_hold_full;
    assign w_last_tick = baud_tick & (r_tick_cnt == c_TICK_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Holding register: set by an accepted load, emptied by the transfer into
    // the shift register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_transfer) begin
            r_hold_full <= 1'b0;
        end else if (w_load_ok) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic. Nothing moves unless baud_tick is high,
    // so holding baud_tick low freezes the frame with TxD stable.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_transfer  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (baud_tick && r_hold_full) begin
                    w_transfer  = 1'b1;
                    w_state_nxt = S_START;
                    w_tick_nxt  = 4'd0;
                end
            end

            S_START: begin
                if (w_last_tick) begin
                    w_tick_nxt  = 4'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end

            S_DATA: begin
                if (w_last_tick) begin
                    w_tick_nxt  = 4'd0;
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end

            S_STOP: begin
                if (w_last_tick) begin
                    w_tick_nxt = 4'd0;
                    // A byte already waiting starts immediately after the
                    // stop bit, so consecutive frames have no idle gap.
                    if (r_hold_full) begin
                        w_transfer  = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (baud_tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = 4'd0;
                w_bit_nxt   = 3'd0;
            end
        endcase

        if (w_transfer) begin
            w_shift_nxt = r_hold;
        end

        // The line level is computed from the next state and next shift
        // contents and then registered, so TxD changes exactly on the edge
        // that enters each bit and never glitches.
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign TxD     = r_txd;
    assign TBR     = ~r_hold_full;
    assign tx_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. A frame-level reference model
//             predicts TxD/TBR/tx_busy every cycle, and a behavioural serial
//             receiver decodes the line back into bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int FRAME = (DB + 2) * OS;

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_tick;
    logic          tx_load;
    logic [DB-1:0] tx_data;
    logic          TxD;
    logic          TBR;
    logic          tx_busy;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_tick(baud_tick),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .TxD      (TxD),
        .TBR      (TBR),
        .tx_busy  (tx_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is an array of DB+2 line levels, and the
    // position counts baud ticks since the frame began.
    bit            m_full   = 0;
    logic [DB-1:0] m_hold   = '0;
    bit            m_active = 0;
    logic [DB+1:0] m_frame  = '1;
    int            m_pos    = 0;
    logic [DB-1:0] m_acc[$];

    // Behavioural receiver
    bit            rx_active = 0;
    int            rx_ticks  = 0;
    logic [DB-1:0] rx_byte   = '0;
    logic [DB-1:0] rx_q[$];
    logic          prev_txd  = 1'b1;

    int busy_cycles = 0;
    int cyc         = 0;
    int tick_per    = 1;

    typedef struct {
        int            per;
        logic [DB-1:0] b0;
        logic [DB-1:0] b1;
        int            mode;   // 0 single, 1 back-to-back, 2 ignored load
        int            nexp;
        logic [DB-1:0] e0;
        logic [DB-1:0] e1;
    } vec_t;

    vec_t vt[12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit tk();
        return (cyc % tick_per) == 0;
    endfunction

    task automatic model_edge(bit rst, bit tick, bit load, logic [DB-1:0] d);
        bit do_load;
        if (rst) begin
            m_full   = 0;
            m_hold   = '0;
            m_active = 0;
            m_pos    = 0;
            return;
        end
        do_load = load && !m_full;
        if (tick) begin
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) m_active = 0;
            end
            if (!m_active && m_full) begin
                m_frame  = {1'b1, m_hold, 1'b0};
                m_pos    = 0;
                m_active = 1;
                m_full   = 0;
            end
        end
        if (do_load) begin
            m_full = 1;
            m_hold = d;
            m_acc.push_back(d);
        end
    endtask

    task automatic step(bit rst, bit tick, bit load, logic [DB-1:0] d);
        logic exp_txd;
        int   k;
        reset     = rst;
        baud_tick = tick;
        tx_load   = load;
        tx_data   = d;
        @(posedge clk);
        cyc++;
        model_edge(rst, tick, load, d);
        #1;
        exp_txd = m_active ? m_frame[m_pos / OS] : 1'b1;
        chk("TxD", TxD, exp_txd);
        chk("TBR", TBR, !m_full);
        chk("tx_busy", tx_busy, m_active);
        if (!rst && !tick) chk("TxD_stable_without_tick", TxD, prev_txd);
        if (tx_busy === 1'b1) busy_cycles++;

        if (rst) begin
            rx_active = 0;
        end else begin
            if (rx_active && tick) begin
                rx_ticks++;
                if (rx_ticks % OS == OS / 2) begin
                    k = rx_ticks / OS;
                    if (k >= 1 && k <= DB) begin
                        rx_byte[k-1] = TxD;
                    end else if (k == DB + 1) begin
                        if (TxD === 1'b1) rx_q.push_back(rx_byte);
                        rx_active = 0;
                    end
                end
            end
            if (!rx_active && prev_txd === 1'b1 && TxD === 1'b0) begin
                rx_active = 1;
                rx_ticks  = 0;
            end
        end
        prev_txd = TxD;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((m_active || m_full) && n < budget) begin
            step(0, tk(), 0, '0);
            n++;
        end
        chk("drain_done", 32'(m_active || m_full), 32'd0);
        repeat (4) step(0, tk(), 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
    endtask

    initial begin
        logic [DB-1:0] r0, r1;
        int            n;

        vt[0]  = '{1, 8'hA5, 8'h00, 0, 1, 8'hA5, 8'h00};
        vt[1]  = '{1, 8'h55, 8'h0F, 1, 2, 8'h55, 8'h0F};
        vt[2]  = '{1, 8'h11, 8'h22, 2, 1, 8'h11, 8'h00};
        vt[3]  = '{5, 8'h3C, 8'h00, 0, 1, 8'h3C, 8'h00};
        vt[4]  = '{1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00};
        vt[5]  = '{1, 8'hFF, 8'h00, 0, 1, 8'hFF, 8'h00};
        vt[6]  = '{1, 8'h80, 8'h00, 0, 1, 8'h80, 8'h00};
        vt[7]  = '{1, 8'h01, 8'h00, 0, 1, 8'h01, 8'h00};
        vt[8]  = '{3, 8'hC3, 8'h7E, 1, 2, 8'hC3, 8'h7E};
        vt[9]  = '{5, 8'h96, 8'h69, 2, 1, 8'h96, 8'h00};
        r0 = DB'($urandom);
        r1 = DB'($urandom);
        vt[10] = '{2, r0, r1, 1, 2, r0, r1};
        r0 = DB'($urandom);
        r1 = DB'($urandom);
        vt[11] = '{1, r0, r1, 2, 1, r0, 8'h00};

        // Reset state
        do_reset();
        chk("reset_TxD", TxD, 1'b1);
        chk("reset_TBR", TBR, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);

        // Table-driven frame scenarios
        for (int i = 0; i < 12; i++) begin
            tick_per = vt[i].per;
            do_reset();
            rx_q.delete();
            m_acc.delete();
            busy_cycles = 0;
            repeat (3) step(0, tk(), 0, '0);
            if (vt[i].mode == 2) begin
                // Ticks held off so the byte stays parked and TBR stays low
                step(0, 0, 1, vt[i].b0);
                step(0, 0, 1, vt[i].b1);
                step(0, 0, 1, vt[i].b1);
                chk("TBR_low_while_full", TBR, 1'b0);
            end else begin
                step(0, tk(), 1, vt[i].b0);
            end
            if (vt[i].mode == 1) begin
                n = 0;
                while (m_full && n < 10 * tick_per + 10) begin
                    step(0, tk(), 0, '0);
                    n++;
                end
                step(0, tk(), 1, vt[i].b1);
            end
            drain(4 * FRAME * tick_per + 50);
            chk("frames_decoded", rx_q.size(), vt[i].nexp);
            if (rx_q.size() >= 1) chk("byte0", rx_q[0], vt[i].e0);
            if (vt[i].nexp == 2 && rx_q.size() >= 2) chk("byte1", rx_q[1], vt[i].e1);
            chk("busy_cycles", busy_cycles, vt[i].nexp * FRAME * vt[i].per);
        end

        // Mid-frame reset during data bit 3 of 0xFF, with a second byte
        // pending that must be discarded.
        tick_per = 1;
        do_reset();
        rx_q.delete();
        step(0, tk(), 1, 8'hFF);
        step(0, tk(), 0, '0);
        step(0, tk(), 1, 8'h3C);
        n = 0;
        while (!(m_active && m_pos == 4 * OS + 5) && n < 2 * FRAME) begin
            step(0, tk(), 0, '0);
            n++;
        end
        chk("reached_bit3", 32'(m_active && m_pos == 4 * OS + 5), 32'd1);
        chk("bit3_level", TxD, 1'b1);
        // Freeze: no ticks, TxD must hold
        repeat (20) step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("midreset_TxD", TxD, 1'b1);
        chk("midreset_TBR", TBR, 1'b1);
        chk("midreset_busy", tx_busy, 1'b0);
        busy_cycles = 0;
        repeat (2 * FRAME) step(0, tk(), 0, '0);
        chk("no_resume_busy", busy_cycles, 0);
        chk("no_resume_frames", rx_q.size(), 0);

        // Randomised traffic against the reference model
        do_reset();
        rx_q.delete();
        m_acc.delete();
        for (int s = 0; s < 4000; s++) begin
            step(0, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, DB'($urandom));
        end
        tick_per = 1;
        drain(4 * FRAME + 50);
        chk("random_frame_count", rx_q.size(), m_acc.size());
        for (int j = 0; j < m_acc.size() && j < rx_q.size(); j++) begin
            chk("random_byte", rx_q[j], m_acc[j]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
